// File: rtl/dmem_resp.sv
// dmem_resp: byte-addressed little-endian data memory that answers an LSU
// request after a fixed number of wait states with a one-cycle ready strobe.
// Optional fault checking is enabled with `define DMEM_RESP_ERR_EN.
module dmem_resp #(
    parameter int unsigned DMEM_SIZE   = 128,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        mem_req_i,
    input  logic        mem_we_i,
    input  logic [2:0]  mem_size_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    output logic [31:0] mem_rdata_o,
    output logic        mem_ready_o,
    output logic        mem_err_o
);

    localparam int unsigned AW        = $clog2(DMEM_SIZE);
    localparam int unsigned IW        = AW - 2;
    localparam int unsigned DEPTH     = DMEM_SIZE / 4;
    localparam logic [3:0]  WAIT_LAST = 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    typedef struct packed {
        logic        we;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    txn_t            cap_q, cur;
    logic [31:0]     mem [DEPTH];
    logic [IW-1:0]   word_idx;
    logic [31:0]     rd_word, load_data, wr_data;
    logic [7:0]      rd_byte;
    logic [15:0]     rd_half;
    logic [3:0]      wr_be;
    logic            fault, accept, wr_en;
    logic            ready_d, err_d;
    logic [31:0]     rdata_d;

    // Transaction being decoded: live inputs while idle, captured copy otherwise
    always_comb begin
        cur = cap_q;
        if (state_q == S_IDLE) begin
            cur = '{we: mem_we_i, size: mem_size_i, addr: mem_addr_i, wdata: mem_wdata_i};
        end
    end

    assign accept   = (state_q == S_IDLE) && mem_req_i;
    assign word_idx = cur.addr[AW-1:2];
    assign rd_word  = mem[word_idx];

`ifdef DMEM_RESP_ERR_EN
    // Fault on illegal size, misaligned H/W or out-of-range address
    always_comb begin
        fault = 1'b0;
        if (cur.size inside {3'b011, 3'b110, 3'b111}) fault = 1'b1;
        if ((cur.size inside {3'b001, 3'b101}) && cur.addr[0]) fault = 1'b1;
        if ((cur.size == 3'b010) && (cur.addr[1:0] != 2'b00)) fault = 1'b1;
        if (cur.addr >= 32'(DMEM_SIZE)) fault = 1'b1;
    end
`else
    // Without checking, upper address bits wrap and sub-word misalignment is ignored
    logic unused_addr;
    assign unused_addr = ^cur.addr[31:AW];
    assign fault       = 1'b0;
`endif

    // Load lane selection and extension
    always_comb begin
        rd_byte   = 8'(rd_word >> {cur.addr[1:0], 3'b000});
        rd_half   = cur.addr[1] ? rd_word[31:16] : rd_word[15:0];
        load_data = rd_word;
        case (cur.size)
            3'b000:  load_data = {{24{rd_byte[7]}}, rd_byte};
            3'b100:  load_data = {24'h0, rd_byte};
            3'b001:  load_data = {{16{rd_half[15]}}, rd_half};
            3'b101:  load_data = {16'h0, rd_half};
            default: load_data = rd_word;
        endcase
    end

    // Store byte enables and lane-replicated write data
    always_comb begin
        wr_be   = 4'b1111;
        wr_data = cur.wdata;
        case (cur.size)
            3'b000, 3'b100: begin
                wr_be   = 4'(4'b0001 << cur.addr[1:0]);
                wr_data = {4{cur.wdata[7:0]}};
            end
            3'b001, 3'b101: begin
                wr_be   = cur.addr[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{cur.wdata[15:0]}};
            end
            default: begin
                wr_be   = 4'b1111;
                wr_data = cur.wdata;
            end
        endcase
    end

    // State register and wait counter
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (mem_req_i) begin
                    cnt_d   = 4'd0;
                    state_d = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == WAIT_LAST) begin
                    cnt_d   = 4'd0;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output values for the coming cycle, plus the store strobe
    always_comb begin
        ready_d = (state_d == S_RESP);
        err_d   = ready_d && fault;
        rdata_d = 32'h0;
        if (ready_d && !cur.we && !fault) rdata_d = load_data;
        wr_en   = (state_q == S_RESP) && cur.we && !fault;
    end

    // Registered outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mem_ready_o <= 1'b0;
            mem_err_o   <= 1'b0;
            mem_rdata_o <= 32'h0;
        end else begin
            mem_ready_o <= ready_d;
            mem_err_o   <= err_d;
            mem_rdata_o <= rdata_d;
        end
    end

    // Capture the request at acceptance
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cap_q <= '0;
        end else if (accept) begin
            cap_q <= cur;
        end
    end

    // Storage array, written on the edge leaving the response cycle
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) mem[word_idx][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

endmodule

// File: doc/dmem_resp.md
DMEM_RESP -- requirements
Module: dmem_resp

Interface
REQ-001 SHALL have parameter DMEM_SIZE, default 128, memory size in bytes (multiple of 4, power of 2).
REQ-002 SHALL have parameter WAIT_STATES, default 1, extra cycles between acceptance and response (0..15).
REQ-003 SHALL use one clock and an asynchronous active-low reset: clk input, rstn input.
REQ-004 SHALL have ports: clk  in  1  clock (rising edge).
REQ-005 SHALL have ports: rstn  in  1  async active-low reset.
REQ-006 SHALL have ports: mem_req_i  in  1  access request from LSU.
REQ-007 SHALL have ports: mem_we_i  in  1  1=store, 0=load.
REQ-008 SHALL have ports: mem_size_i  in  3  000=B, 001=H, 010=W, 100=BU, 101=HU.
REQ-009 SHALL have ports: mem_addr_i  in  32  byte address.
REQ-010 SHALL have ports: mem_wdata_i  in  32  store data, right-aligned (B in [7:0], H in [15:0]).
REQ-011 SHALL have ports: mem_rdata_o  out  32  load data, extended per size.
REQ-012 SHALL have ports: mem_ready_o  out  1  one-cycle completion strobe; LSU stall = mem_req_i & ~mem_ready_o.
REQ-013 SHALL have ports: mem_err_o  out  1  access fault, valid only while mem_ready_o=1.

Function
REQ-014 SHALL implement FSM IDLE, WAIT, RESP; storage = DMEM_SIZE/4 32-bit words, little-endian.
REQ-015 SHALL capture we, size, addr, wdata at the rising edge where state=IDLE and mem_req_i=1; go to WAIT if WAIT_STATES>0, else RESP.
REQ-016 SHALL count WAIT_STATES cycles in WAIT with a 4-bit counter, then go to RESP.
REQ-017 SHALL assert mem_ready_o exactly for the one cycle in RESP, then return to IDLE.
REQ-018 SHALL ignore mem_req_i and all inputs in WAIT and RESP; captured transaction completes even if mem_req_i drops.
REQ-019 SHALL treat mem_req_i=1 in the IDLE cycle after RESP as a new transaction (back-to-back); no transaction lost or duplicated.
REQ-020 SHALL perform stores at the edge leaving RESP, byte enables from addr[1:0]: B one lane, H lanes addr[1]*2..+1, W all four.
REQ-021 SHALL drive mem_rdata_o during RESP: B/H sign-extended, BU/HU zero-extended, W unmodified, lane selected by addr[1:0].
REQ-022 SHALL drive mem_rdata_o=0 outside RESP and on stores.
REQ-023 SHALL treat sizes 011, 110, 111 as faults (REQ-027) when DMEM_RESP_ERR_EN defined, else as W.
REQ-024 Load latency = WAIT_STATES+1 cycles from acceptance edge to mem_ready_o high.

Reset
REQ-025 SHALL on rstn=0, immediately: state=IDLE, counter=0, mem_ready_o=0, mem_err_o=0, mem_rdata_o=0.
REQ-026 SHALL discard any in-flight transaction on reset (no store performed); memory contents unaffected by reset.

Configuration
REQ-027 With DMEM_RESP_ERR_EN defined: fault if H/HU with addr[0]=1, W with addr[1:0]!=0, addr>=DMEM_SIZE, or illegal size; fault gives mem_err_o=1 with mem_ready_o, no store, mem_rdata_o=0; same latency.
REQ-028 Without DMEM_RESP_ERR_EN: mem_err_o tied 0; address taken modulo DMEM_SIZE; H ignores addr[0], W ignores addr[1:0].

Verification (WAIT_STATES=1 unless stated)
REQ-029 Stores B 0x00<-0x111111AA, B 0x01<-0x222222CC, H 0x02<-0x3333BBBB, W 0x04<-0x1111FAFB -> each ready 2 cycles after acceptance, err=0; load W 0x00 = 0xBBBBCCAA.
REQ-030 After REQ-029: load HU 0x00 -> 0x0000CCAA; load B 0x05 -> 0xFFFFFFFA; load H 0x02 -> 0xFFFFBBBB; load BU 0x07 -> 0x00000011.
REQ-031 ERR_EN defined: store W 0x02<-0xDEADBEEF -> err=1 with ready; following load W 0x00 still 0xBBBBCCAA; load W 0x80 -> err=1, rdata=0.
REQ-032 rstn pulsed low during WAIT of store W 0x08<-0x12345678 -> ready never asserts; after reset load W 0x08 returns prior value.
REQ-033 WAIT_STATES=0, req held high for three back-to-back loads -> ready high every second cycle, three responses, correct data each.
REQ-034 mem_req_i dropped in WAIT of store B 0x10<-0x5A -> ready still asserts; load BU 0x10 -> 0x0000005A.
